router_out_arbiter: RTL and testbench

- Per-output-port arbiter for the 16x16 serial router.
- Each input port's header decoder raises a request once it has decoded a packet's destination address equal to this output.
- The arbiter grants one input at a time using round-robin, and holds the grant until that packet's last bit.
- It drives busy_n back to waiting inputs and a one-hot select to the output mux; one instance exists per output port.

---
 rtl/router_out_arbiter.sv | 155 +++++++++++++++
 tb/tb_router_out_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_out_arbiter.sv
// Round-robin output-port arbiter for the 16x16 serial router; holds a grant until the packet's eop.
// Define ROUTER_ARB_WATCHDOG_EN to add a packet-length watchdog and the wdog_err output.
module router_out_arbiter #(
    parameter int NUM_PORTS      = 16,
    parameter int IDX_W          = 4,
    parameter int MAX_PKT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] eop,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid,
    output logic [NUM_PORTS-1:0] busy_n,
    output logic                 abort_err
`ifdef ROUTER_ARB_WATCHDOG_EN
    ,
    output logic                 wdog_err
`endif
);

    if (IDX_W != $clog2(NUM_PORTS) || MAX_PKT_CYCLES < 2) begin : g_param_check
        $error("router_out_arbiter: IDX_W must be clog2(NUM_PORTS) and MAX_PKT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]     sel_idx, idx_wrap, scan_cand;
    logic [IDX_W:0]       scan_sum;
    logic                 sel_found;
    logic [NUM_PORTS-1:0] grant_next;
    logic [IDX_W-1:0]     grant_idx_next;
    logic                 grant_valid_next;
    logic                 abort_next;
    logic                 release_now;

`ifdef ROUTER_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(MAX_PKT_CYCLES);
    logic [CNT_W-1:0] wdog_cnt;
    logic             wdog_next;
`endif

    // Find the first requester at or above rr_ptr, wrapping past the top port.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_sum  = '0;
        scan_cand = '0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (scan_sum >= (IDX_W+1)'(NUM_PORTS)) begin
                scan_sum = scan_sum - (IDX_W+1)'(NUM_PORTS);
            end
            scan_cand = scan_sum[IDX_W-1:0];
            if (!sel_found && req[scan_cand]) begin
                sel_found = 1'b1;
                sel_idx   = scan_cand;
            end
        end
    end

    assign idx_wrap = (grant_idx == IDX_W'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
    assign busy_n   = ~req | grant;

    always_comb begin
        state_next       = state;
        grant_next       = grant;
        grant_idx_next   = grant_idx;
        grant_valid_next = grant_valid;
        rr_ptr_next      = rr_ptr;
        abort_next       = 1'b0;
        release_now      = 1'b0;
`ifdef ROUTER_ARB_WATCHDOG_EN
        wdog_next        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_next          = '0;
                    grant_next[sel_idx] = 1'b1;
                    grant_idx_next      = sel_idx;
                    grant_valid_next    = 1'b1;
                    state_next          = HOLD;
                end
            end
            HOLD: begin
                // Only the granted port's req/eop matter; everything else is ignored here.
                if (req[grant_idx] && eop[grant_idx]) begin
                    release_now = 1'b1;
                end else if (!req[grant_idx]) begin
                    release_now = 1'b1;
                    abort_next  = 1'b1;
                end
`ifdef ROUTER_ARB_WATCHDOG_EN
                else if (wdog_cnt == CNT_W'(MAX_PKT_CYCLES-1)) begin
                    release_now = 1'b1;
                    wdog_next   = 1'b1;
                end
`endif
                if (release_now) begin
                    grant_next       = '0;
                    grant_idx_next   = '0;
                    grant_valid_next = 1'b0;
                    rr_ptr_next      = idx_wrap;
                    state_next       = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            abort_err   <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_idx   <= grant_idx_next;
            grant_valid <= grant_valid_next;
            abort_err   <= abort_next;
            rr_ptr      <= rr_ptr_next;
        end
    end

`ifdef ROUTER_ARB_WATCHDOG_EN
    // Counter sits at zero outside HOLD, so it restarts on every new grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= wdog_next;
            if (state != HOLD || release_now) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// Testbench for router_out_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_router_out_arbiter;

    localparam int N    = 16;
    localparam int MAXC = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  eop   = '0;
    logic [N-1:0]  grant;
    logic [3:0]    grant_idx;
    logic          grant_valid;
    logic [N-1:0]  busy_n;
    logic          abort_err;
`ifdef ROUTER_ARB_WATCHDOG_EN
    logic          wdog_err;
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    router_out_arbiter #(.NUM_PORTS(N), .IDX_W(4), .MAX_PKT_CYCLES(MAXC)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .eop         (eop),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy_n      (busy_n),
`ifdef ROUTER_ARB_WATCHDOG_EN
        .wdog_err    (wdog_err),
`endif
        .abort_err   (abort_err)
    );

    always #5 clock = ~clock;

    // Reference model: who owns the output, whether we are in the turnaround cycle, and the fairness pointer.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_ptr   = 0;
    bit m_abort = 1'b0;
    bit m_wdog  = 1'b0;
    int m_cnt   = 0;

    function automatic int first_from(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[4'((p + k) % N)]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_abort = 1'b0; m_wdog = 1'b0; m_cnt = 0;
        end else begin
            m_abort = 1'b0;
            m_wdog  = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_owner < 0) begin
                if (req != '0) begin
                    m_owner = first_from(m_ptr, req);
                    m_cnt   = 0;
                end
            end else if (!req[4'(m_owner)] || eop[4'(m_owner)] || (WDOG && m_cnt == MAXC-1)) begin
                m_abort = !req[4'(m_owner)];
                m_wdog  = req[4'(m_owner)] && !eop[4'(m_owner)];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; eop = '0;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic wait_grant();
        for (int w = 0; w < 6 && !grant_valid; w++) cycles(1);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; eop = '0;
        cycles(2);
        n_cmp++;
        if ({grant_valid, grant_idx, grant} !== 21'h0) begin
            n_fail++; $display("[TB] FAIL reset_grant: got %h, want 0", {grant_valid, grant_idx, grant});
        end
        n_cmp++;
        if (abort_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_abort: got %b, want 0", abort_err);
        end
        n_cmp++;
        if (busy_n !== 16'hFFFF) begin
            n_fail++; $display("[TB] FAIL reset_busy_n: got %h, want ffff", busy_n);
        end
        req = 16'h0001;
        cycles(1);
        n_cmp++;
        if (grant_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_holds_idle: got %b, want 0", grant_valid);
        end
        reset = 1'b0; req = '0;
        cycles(1);
    endtask

    task automatic test_single();
        do_reset();
        req = 16'h0008;
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant_idx, grant} !== {1'b1, 4'd3, 16'h0008}) begin
            n_fail++; $display("[TB] FAIL single_grant: got %h, want %h", {grant_valid, grant_idx, grant}, {1'b1, 4'd3, 16'h0008});
        end
        cycles(19);
        n_cmp++;
        if ({grant_valid, grant} !== {1'b1, 16'h0008} || busy_n !== 16'hFFFF) begin
            n_fail++; $display("[TB] FAIL single_hold: got grant %h busy_n %h, want 0008 ffff", grant, busy_n);
        end
        eop = 16'h0008;
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant_idx, grant} !== 21'h0 || abort_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_release: got %h abort %b, want 0 0", {grant_valid, grant_idx, grant}, abort_err);
        end
        n_cmp++;
        if (busy_n !== 16'hFFF7) begin
            n_fail++; $display("[TB] FAIL single_gap_busy_n: got %h, want fff7", busy_n);
        end
        eop = '0;
        cycles(1);
        n_cmp++;
        if (grant_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_gap_no_grant: got %b, want 0", grant_valid);
        end
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant} !== {1'b1, 16'h0008}) begin
            n_fail++; $display("[TB] FAIL single_regrant: got %h, want 10008", {grant_valid, grant});
        end
        eop = 16'h0008;
        cycles(1);
        req = '0; eop = '0;
        cycles(2);
    endtask

    task automatic test_fairness();
        do_reset();
        req = 16'hFFFF;
        for (int k = 0; k <= N; k++) begin
            cycles(1);
            wait_grant();
            n_cmp++;
            if ({grant_valid, grant_idx} !== {1'b1, 4'(k % N)}) begin
                n_fail++; $display("[TB] FAIL fair_order_%0d: got %h, want %h", k, {grant_valid, grant_idx}, {1'b1, 4'(k % N)});
            end
            n_cmp++;
            if (busy_n !== (16'h1 << (k % N))) begin
                n_fail++; $display("[TB] FAIL fair_busy_n_%0d: got %h, want %h", k, busy_n, 16'h1 << (k % N));
            end
            cycles(9);
            eop = 16'h1 << (k % N);
            cycles(1);
            eop = '0;
        end
        req = '0;
        cycles(3);
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h2000;
        cycles(1);
        eop = 16'h2000;
        cycles(1);
        eop = '0; req = 16'h4001;
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd14}) begin
            n_fail++; $display("[TB] FAIL wrap_first: got %h, want 1e", {grant_valid, grant_idx});
        end
        eop = 16'h4000;
        cycles(1);
        eop = '0; req = 16'h0001;
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd0}) begin
            n_fail++; $display("[TB] FAIL wrap_to_zero: got %h, want 10", {grant_valid, grant_idx});
        end
        eop = 16'h0001;
        cycles(1);
        eop = '0; req = '0;
        cycles(2);
    endtask

    task automatic test_abort();
        do_reset();
        req = 16'h0020;
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd5}) begin
            n_fail++; $display("[TB] FAIL abort_setup: got %h, want 15", {grant_valid, grant_idx});
        end
        req = 16'h0224;
        cycles(5);
        req = 16'h0204;
        cycles(1);
        n_cmp++;
        if ({abort_err, grant_valid, grant} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++; $display("[TB] FAIL abort_pulse: got abort %b grant %h, want 1 0", abort_err, grant);
        end
        cycles(1);
        n_cmp++;
        if (abort_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_one_cycle: got %b, want 0", abort_err);
        end
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd9}) begin
            n_fail++; $display("[TB] FAIL abort_next_grant: got %h, want 19", {grant_valid, grant_idx});
        end
        eop = 16'h0200;
        cycles(1);
        eop = '0; req = 16'h0004;
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd2}) begin
            n_fail++; $display("[TB] FAIL abort_then_wrap: got %h, want 12", {grant_valid, grant_idx});
        end
        eop = 16'h0004;
        cycles(1);
        eop = '0; req = '0;
        cycles(2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 16'h0200;
        cycles(1);
        eop = 16'h0200;
        cycles(1);
        eop = '0;
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd9}) begin
            n_fail++; $display("[TB] FAIL midreset_setup: got %h, want 19", {grant_valid, grant_idx});
        end
        cycles(3);
        reset = 1'b1;
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant_idx, grant, abort_err} !== 22'h0) begin
            n_fail++; $display("[TB] FAIL midreset_clear: got %h, want 0", {grant_valid, grant_idx, grant, abort_err});
        end
        reset = 1'b0; req = 16'h0600;
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd9}) begin
            n_fail++; $display("[TB] FAIL midreset_ptr_zero: got %h, want 19", {grant_valid, grant_idx});
        end
        eop = 16'h0200;
        cycles(1);
        eop = '0; req = '0;
        cycles(2);
    endtask

    task automatic test_eop_noise();
        logic [N-1:0] other;
        do_reset();
        req = 16'h0010;
        cycles(1);
        for (int c = 0; c < 8; c++) begin
            other = 16'($urandom) & ~16'h0010;
            eop = other;
            req = 16'h0010 | 16'($urandom);
            cycles(1);
            n_cmp++;
            if ({grant_valid, grant, abort_err} !== {1'b1, 16'h0010, 1'b0}) begin
                n_fail++; $display("[TB] FAIL noise_ignored_%0d: got %h, want 20020", c, {grant_valid, grant, abort_err});
            end
        end
        req = 16'h0010; eop = 16'h0010;
        cycles(1);
        req = '0; eop = '0;
        cycles(2);
    endtask

    task automatic test_random();
        int           left [N];
        logic [N-1:0] epk;
        logic [N-1:0] noise;
        logic [N-1:0] exp_grant;
        do_reset();
        epk = '0;
        for (int i = 0; i < N; i++) left[i] = 0;
        for (int c = 0; c < 400; c++) begin
            exp_grant = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
            n_cmp++;
            if (grant !== exp_grant || grant_valid !== (m_owner >= 0)) begin
                n_fail++; $display("[TB] FAIL rand_grant_c%0d: got %h/%b, want %h/%b", c, grant, grant_valid, exp_grant, m_owner >= 0);
            end
            n_cmp++;
            if (grant_idx !== ((m_owner >= 0) ? 4'(m_owner) : 4'd0)) begin
                n_fail++; $display("[TB] FAIL rand_idx_c%0d: got %0d, want %0d", c, grant_idx, (m_owner >= 0) ? m_owner : 0);
            end
            n_cmp++;
            if (busy_n !== (~req | exp_grant)) begin
                n_fail++; $display("[TB] FAIL rand_busy_n_c%0d: got %h, want %h", c, busy_n, ~req | exp_grant);
            end
            n_cmp++;
            if (abort_err !== m_abort) begin
                n_fail++; $display("[TB] FAIL rand_abort_c%0d: got %b, want %b", c, abort_err, m_abort);
            end
`ifdef ROUTER_ARB_WATCHDOG_EN
            n_cmp++;
            if (wdog_err !== m_wdog) begin
                n_fail++; $display("[TB] FAIL rand_wdog_c%0d: got %b, want %b", c, wdog_err, m_wdog);
            end
`endif
            for (int i = 0; i < N; i++) begin
                if (epk[4'(i)]) begin
                    req[4'(i)] = 1'b0;
                    epk[4'(i)] = 1'b0;
                end else if (req[4'(i)] && m_owner == i) begin
                    if ($urandom_range(0, 24) == 0) begin
                        req[4'(i)] = 1'b0;
                    end else begin
                        left[i]--;
                        if (left[i] <= 0) epk[4'(i)] = 1'b1;
                    end
                end else if (!req[4'(i)] && $urandom_range(0, 3) == 0) begin
                    req[4'(i)] = 1'b1;
                    left[i]    = int'($urandom_range(1, 8));
                end
            end
            noise = 16'($urandom) & 16'($urandom) & ~epk;
            if (m_owner >= 0) noise[4'(m_owner)] = 1'b0;
            eop = epk | noise;
            cycles(1);
        end
        req = '0; eop = '0;
        cycles(3);
    endtask

`ifdef ROUTER_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        req = 16'h000C;
        cycles(1);
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd2}) begin
            n_fail++; $display("[TB] FAIL wdog_setup: got %h, want 12", {grant_valid, grant_idx});
        end
        cycles(MAXC - 1);
        n_cmp++;
        if ({grant_valid, grant_idx, wdog_err} !== {1'b1, 4'd2, 1'b0}) begin
            n_fail++; $display("[TB] FAIL wdog_not_early: got %h, want 24", {grant_valid, grant_idx, wdog_err});
        end
        cycles(1);
        n_cmp++;
        if ({grant_valid, wdog_err, abort_err} !== 3'b010) begin
            n_fail++; $display("[TB] FAIL wdog_release: got %b, want 010", {grant_valid, wdog_err, abort_err});
        end
        req = 16'h0008;
        cycles(1);
        n_cmp++;
        if (wdog_err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wdog_one_cycle: got %b, want 0", wdog_err);
        end
        wait_grant();
        n_cmp++;
        if ({grant_valid, grant_idx} !== {1'b1, 4'd3}) begin
            n_fail++; $display("[TB] FAIL wdog_next_grant: got %h, want 13", {grant_valid, grant_idx});
        end
        eop = 16'h0008;
        cycles(1);
        req = '0; eop = '0;
        cycles(2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_eop_noise();
        test_random();
`ifdef ROUTER_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, want finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
